seg7_scan_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment display interface: watches segment lines and

---
 rtl/seg7_scan_capture.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Receive side of a multiplexed 7-segment display link. Watches the segment
//   lines and the active-low digit selects and recovers the value shown on
//   each digit. One record is emitted per stable digit strobe over a
//   valid/ready port, and a per-digit table holds the last good value.
//
//   Optional feature macro: HEX_DECODE_EN adds the A..F glyphs to the decoder.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   seg        in   [6:0] segment lines {g,f,e,d,c,b,a}, 1 = lit
//   dig_sel_n  in   [NDIG-1:0] active-low digit selects
//   out_ready  in   consumer accepts the current record
//   ovf_clr    in   clears the sticky overflow flag
//   out_valid  out  record available
//   out_idx    out  [IDX_W-1:0] digit position of the record
//   out_val    out  [3:0] decoded value (0 on error or blank)
//   out_err    out  pattern not in the decode table
//   out_blank  out  pattern all-off
//   digits     out  [4*NDIG-1:0] last good value per position, digit i at [4i+3:4i]
//   ovf        out  sticky: a capture was dropped because a record was still held
module seg7_scan_capture #(
    parameter int NDIG       = 4,
    parameter int IDX_W      = 2,
    parameter int STABLE_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   dig_sel_n,
    input  logic              out_ready,
    input  logic              ovf_clr,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic [3:0]        out_val,
    output logic              out_err,
    output logic              out_blank,
    output logic [4*NDIG-1:0] digits,
    output logic              ovf
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t           state, nxt_state;
    logic [IDX_W-1:0] lat_idx;
    logic [6:0]       lat_seg;
    logic [CNT_W-1:0] cnt, nxt_cnt;

    logic [NDIG-1:0]  sel;
    logic             samp_onehot;
    logic [IDX_W-1:0] samp_idx;
    logic             samp_same;
    logic             do_latch;
    logic             do_emit;
    logic [5:0]       dec;

    // Returns {err, blank, val[3:0]}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'h00: decode = 6'b01_0000;
            7'h3F: decode = 6'b00_0000;
            7'h06: decode = 6'b00_0001;
            7'h5B: decode = 6'b00_0010;
            7'h4F: decode = 6'b00_0011;
            7'h66: decode = 6'b00_0100;
            7'h6D: decode = 6'b00_0101;
            7'h7D: decode = 6'b00_0110;
            7'h07: decode = 6'b00_0111;
            7'h7F: decode = 6'b00_1000;
            7'h6F: decode = 6'b00_1001;
`ifdef HEX_DECODE_EN
            7'h77: decode = 6'b00_1010;
            7'h7C: decode = 6'b00_1011;
            7'h39: decode = 6'b00_1100;
            7'h5E: decode = 6'b00_1101;
            7'h79: decode = 6'b00_1110;
            7'h71: decode = 6'b00_1111;
`endif
            default: decode = 6'b10_0000;
        endcase
    endfunction

    assign sel         = ~dig_sel_n;
    // Exactly one select low: non-zero and a power of two.
    assign samp_onehot = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);

    always_comb begin
        samp_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) samp_idx = IDX_W'(i);
        end
    end

    assign samp_same = samp_onehot && (samp_idx == lat_idx) && (seg == lat_seg);
    assign dec       = decode(seg);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        do_latch  = 1'b0;
        do_emit   = 1'b0;
        case (state)
            IDLE: begin
                if (samp_onehot) begin
                    do_latch  = 1'b1;
                    nxt_cnt   = CNT_W'(1);
                    nxt_state = SETTLE;
                end
            end
            SETTLE: begin
                if (samp_same) begin
                    nxt_cnt = cnt + CNT_W'(1);
                end else if (samp_onehot) begin
                    do_latch = 1'b1;
                    nxt_cnt  = CNT_W'(1);
                end else begin
                    nxt_state = IDLE;
                end
            end
            HOLD: begin
                // A strobe already captured stays here until anything changes.
                if (!samp_same) begin
                    if (samp_onehot) begin
                        do_latch  = 1'b1;
                        nxt_cnt   = CNT_W'(1);
                        nxt_state = SETTLE;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
        // The emitting sample is always the current one, which equals the latch.
        if (nxt_state == SETTLE && nxt_cnt == CNT_W'(STABLE_CYC)) begin
            do_emit   = 1'b1;
            nxt_state = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_seg   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_val   <= '0;
            out_err   <= 1'b0;
            out_blank <= 1'b0;
            digits    <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (do_latch) begin
                lat_idx <= samp_idx;
                lat_seg <= seg;
            end
            if (do_emit) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_idx   <= samp_idx;
                    out_val   <= dec[3:0];
                    out_err   <= dec[5];
                    out_blank <= dec[4];
                end
                // The table is updated even when the record itself is dropped.
                if (!dec[5] && !dec[4]) digits[4*samp_idx +: 4] <= dec[3:0];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A new overflow wins over a simultaneous clear.
            if (ovf_clr) ovf <= 1'b0;
            if (do_emit && out_valid && !out_ready) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

    localparam int NDIG   = 4;
    localparam int IDX_W  = 2;
    localparam int STABLE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        seg = 7'h00;
    logic [NDIG-1:0]   dig_sel_n = 4'hF;
    logic              out_ready = 1'b0;
    logic              ovf_clr = 1'b0;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [3:0]        out_val;
    logic              out_err;
    logic              out_blank;
    logic [4*NDIG-1:0] digits;
    logic              ovf;

    seg7_scan_capture #(.NDIG(NDIG), .IDX_W(IDX_W), .STABLE_CYC(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel_n(dig_sel_n),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
        .out_idx(out_idx), .out_val(out_val), .out_err(out_err),
        .out_blank(out_blank), .digits(digits), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Glyph for value v is PATS[v].
    localparam logic [6:0] PATS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                         7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                         7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef HEX_DECODE_EN
    localparam int NGLYPH = 16;
`else
    localparam int NGLYPH = 10;
`endif

    // {err, blank, val}
    function automatic logic [5:0] mdec(input logic [6:0] p);
        if (p == 7'h00) return 6'b01_0000;
        for (int v = 0; v < NGLYPH; v++)
            if (p == PATS[v]) return {2'b00, 4'(v)};
        return 6'b10_0000;
    endfunction

    // Reference model: a capture fires when the same one-hot sample has been
    // seen exactly STABLE times in a row.
    logic              m_valid, m_err, m_blank, m_ovf;
    logic [IDX_W-1:0]  m_idx;
    logic [3:0]        m_val;
    logic [4*NDIG-1:0] m_digits;
    int                run;
    logic              p_oh;
    int                p_idx;
    logic [6:0]        p_seg;
    logic              started = 1'b0;

    always @(posedge clk) begin
        logic c_oh;
        int   c_idx;
        logic emit;
        logic [5:0] d;
        c_oh  = ($countones(~dig_sel_n) == 1);
        c_idx = 0;
        for (int i = 0; i < NDIG; i++) if (!dig_sel_n[i]) c_idx = i;
        if (rst) begin
            m_valid = 0; m_err = 0; m_blank = 0; m_ovf = 0;
            m_idx = 0; m_val = 0; m_digits = 0;
            run = 0; p_oh = 0; p_idx = 0; p_seg = 0;
        end else begin
            if (c_oh && p_oh && c_idx == p_idx && seg == p_seg) run++;
            else run = c_oh ? 1 : 0;
            emit = (run == STABLE);
            d = mdec(seg);
            if (ovf_clr) m_ovf = 0;
            if (emit && m_valid && !out_ready) m_ovf = 1;
            if (emit) begin
                if (!m_valid || out_ready) begin
                    m_valid = 1; m_idx = IDX_W'(c_idx);
                    m_val = d[3:0]; m_err = d[5]; m_blank = d[4];
                end
                if (!d[5] && !d[4]) m_digits[4*c_idx +: 4] = d[3:0];
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            p_oh = c_oh; p_idx = c_idx; p_seg = seg;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", 32'(out_valid), 32'(m_valid));
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
            chk("m_digits", 32'(digits), 32'(m_digits));
            if (m_valid) begin
                chk("m_idx", 32'(out_idx), 32'(m_idx));
                chk("m_val", 32'(out_val), 32'(m_val));
                chk("m_err", 32'(out_err), 32'(m_err));
                chk("m_blank", 32'(out_blank), 32'(m_blank));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_cnt(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid) c++;
        end
    endtask

    initial begin
        int c;
        // 1: reset then a stable "2" on digit 0
        step(1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_rec", {out_idx, out_val, out_err, out_blank}, 0);
        rst = 0; dig_sel_n = 4'b1110; seg = 7'h5B;
        step(2);
        chk("t1_latency", 32'(out_valid), 0);
        step(1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_idx", 32'(out_idx), 0);
        chk("t1_val", 32'(out_val), 2);
        chk("t1_digit0", 32'(digits[3:0]), 2);

        // 2: long strobe gives one record; a new glyph gives another
        out_ready = 1;
        step_cnt(20, c);
        chk("t2_no_repeat", c, 0);
        seg = 7'h4F;
        step(3);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_val", 32'(out_val), 3);
        chk("t2_digit0", 32'(digits[3:0]), 3);

        // 3: glitch restarts settling; invalid glyph flags err
        dig_sel_n = 4'b1101; seg = 7'h66;
        step_cnt(2, c);
        seg = 7'h67;
        step_cnt(2, c);
        chk("t3_glitch", c, 0);
        step(1);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_err", 32'(out_err), 1);
        chk("t3_val", 32'(out_val), 0);
        chk("t3_idx", 32'(out_idx), 1);
        chk("t3_digit1", 32'(digits[7:4]), 0);

        // 4: overflow while a record is held
        dig_sel_n = 4'b1111;
        step(1);
        out_ready = 0; dig_sel_n = 4'b1110; seg = 7'h3F;
        step(3);
        chk("t4_first", 32'(out_valid), 1);
        dig_sel_n = 4'b1101; seg = 7'h06;
        step(3);
        chk("t4_held_idx", 32'(out_idx), 0);
        chk("t4_held_val", 32'(out_val), 0);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_digit1", 32'(digits[7:4]), 1);
        dig_sel_n = 4'b1111; ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        chk("t4_ovf_clr", 32'(ovf), 0);
        dig_sel_n = 4'b1110; seg = 7'h06;
        step(2);
        ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        chk("t4_clr_vs_set", 32'(ovf), 1);
        chk("t4_digit0", 32'(digits[3:0]), 1);
        dig_sel_n = 4'b1111; ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        dig_sel_n = 4'b1101; seg = 7'h5B;
        step(2);
        out_ready = 1;
        step(1);
        chk("t4_popemit_valid", 32'(out_valid), 1);
        chk("t4_popemit_idx", 32'(out_idx), 1);
        chk("t4_popemit_val", 32'(out_val), 2);
        chk("t4_popemit_ovf", 32'(ovf), 0);

        // 5: invalid selects give nothing; blank pattern
        dig_sel_n = 4'b1100;
        step_cnt(10, c);
        chk("t5_multi", c, 0);
        dig_sel_n = 4'b1111;
        step_cnt(10, c);
        chk("t5_none", c, 0);
        dig_sel_n = 4'b0111; seg = 7'h00;
        step(3);
        chk("t5_blank", 32'(out_blank), 1);
        chk("t5_idx", 32'(out_idx), 3);
        chk("t5_err", 32'(out_err), 0);
        chk("t5_digit3", 32'(digits[15:12]), 0);

        // 6: hex glyph A
        dig_sel_n = 4'b1110; seg = 7'h77;
        step(3);
        chk("t6_valid", 32'(out_valid), 1);
`ifdef HEX_DECODE_EN
        chk("t6_val", 32'(out_val), 10);
        chk("t6_err", 32'(out_err), 0);
        chk("t6_digit0", 32'(digits[3:0]), 10);
`else
        chk("t6_val", 32'(out_val), 0);
        chk("t6_err", 32'(out_err), 1);
        chk("t6_digit0", 32'(digits[3:0]), 1);
`endif

        // 7: reset mid-settle discards the partial capture
        dig_sel_n = 4'b1101; seg = 7'h7D;
        step(2);
        rst = 1;
        step(1);
        chk("t7_rst_valid", 32'(out_valid), 0);
        chk("t7_rst_digits", 32'(digits), 0);
        rst = 0;
        step(2);
        chk("t7_restart", 32'(out_valid), 0);
        step(1);
        chk("t7_valid", 32'(out_valid), 1);
        chk("t7_val", 32'(out_val), 6);
        chk("t7_digit1", 32'(digits[7:4]), 6);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
